// File: rtl/block_average_zoom_out.sv
// block_average_zoom_out
//
// Zoom-out engine. Reduces a (2*OUT_W)x(2*OUT_H) 8-bit grayscale frame to
// OUT_W x OUT_H by averaging each 2x2 source block with round-half-up. Each
// averaged pixel is written into a destination frame of the same pitch at a
// window offset that is latched and clamped when the pass starts.
// Every output pixel takes six cycles: four read issues and two accumulate
// cycles to absorb the fixed two-edge read latency of the source RAM.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       level, sampled only in IDLE; starts one frame pass
//   offset_x/y  destination window origin, latched and clamped at start
//   pixel_data  source RAM read data (valid two edges after rd_address update)
//   rd_address  source RAM read address (registered)
//   wr_address  destination RAM write address (registered)
//   wr_data     destination write data (registered)
//   wren        one-cycle write strobe per output pixel
//   busy        high while a pass is in progress
//   done        one-cycle pulse at the end of a pass
module block_average_zoom_out #(
    parameter int SRC_W = 320,
    parameter int OUT_W = 160,
    parameter int OUT_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  offset_x,
    input  logic [7:0]  offset_y,
    input  logic [7:0]  pixel_data,
    output logic [16:0] rd_address,
    output logic [16:0] wr_address,
    output logic [7:0]  wr_data,
    output logic        wren,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD0     = 3'd1,
        RD1     = 3'd2,
        RD2     = 3'd3,
        RD3     = 3'd4,
        ACC0    = 3'd5,
        ACC1    = 3'd6,
        DONE_ST = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [9:0]  sum_q, sum_d;
    logic [7:0]  ox_q, ox_d;
    logic [7:0]  oy_q, oy_d;
    logic [16:0] rd_address_q, rd_address_d;
    logic [16:0] wr_address_q, wr_address_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wren_q, wren_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [8:0]  sx0_s, sx1_s;
    logic [7:0]  sy0_s, sy1_s;
    logic [9:0]  total_s;

    // Linear frame address of (row, col) for the shared line pitch.
    function automatic logic [16:0] pix_addr(input int row, input int col);
        return 17'(row * SRC_W + col);
    endfunction

    // Corners of the 2x2 source block that feeds output pixel (x, y).
    assign sx0_s = {x_q, 1'b0};
    assign sx1_s = {x_q, 1'b1};
    assign sy0_s = {y_q, 1'b0};
    assign sy1_s = {y_q, 1'b1};

    // Fourth sample plus the rounding constant; max 1022 fits in 10 bits.
    assign total_s = sum_q + {2'b00, pixel_data} + 10'd2;

    // Next-state and datapath logic for the pass sequencer.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        sum_d        = sum_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        rd_address_d = rd_address_q;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        wren_d       = wren_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    // Clamp so the window can never run past the frame end.
                    ox_d    = (offset_x > 8'(OUT_W)) ? 8'(OUT_W) : offset_x;
                    oy_d    = (offset_y > 8'(OUT_H)) ? 8'(OUT_H) : offset_y;
                    x_d     = 8'd0;
                    y_d     = 7'd0;
                    busy_d  = 1'b1;
                    state_d = RD0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD0: begin
                rd_address_d = pix_addr(int'(sy0_s), int'(sx0_s));
                wren_d       = 1'b0;
                state_d      = RD1;
            end
            RD1: begin
                rd_address_d = pix_addr(int'(sy0_s), int'(sx1_s));
                state_d      = RD2;
            end
            RD2: begin
                // Data for the RD0 address arrives now.
                rd_address_d = pix_addr(int'(sy1_s), int'(sx0_s));
                sum_d        = {2'b00, pixel_data};
                state_d      = RD3;
            end
            RD3: begin
                rd_address_d = pix_addr(int'(sy1_s), int'(sx1_s));
                sum_d        = sum_q + {2'b00, pixel_data};
                state_d      = ACC0;
            end
            ACC0: begin
                sum_d   = sum_q + {2'b00, pixel_data};
                state_d = ACC1;
            end
            ACC1: begin
                wr_data_d    = total_s[9:2];
                wr_address_d = pix_addr(int'(y_q) + int'(oy_q), int'(x_q) + int'(ox_q));
                wren_d       = 1'b1;
                if (x_q == 8'(OUT_W - 1)) begin
                    x_d = 8'd0;
                    y_d = y_q + 7'd1;
                    if (y_q == 7'(OUT_H - 1)) begin
                        state_d = DONE_ST;
                    end else begin
                        state_d = RD0;
                    end
                end else begin
                    x_d     = x_q + 8'd1;
                    state_d = RD0;
                end
            end
            DONE_ST: begin
                wren_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            sum_q        <= 10'd0;
            ox_q         <= 8'd0;
            oy_q         <= 8'd0;
            rd_address_q <= 17'd0;
            wr_address_q <= 17'd0;
            wr_data_q    <= 8'd0;
            wren_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sum_q        <= sum_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            rd_address_q <= rd_address_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            wren_q       <= wren_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rd_address = rd_address_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign wren       = wren_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/block_average_zoom_out.md
# block_average_zoom_out

Zoom-out engine: reduces a 320x240 8-bit grayscale frame to 160x120 by averaging each 2x2 source block. The 160x120 result is written into a 320x240 destination frame at a programmable window offset. It is the reverse-direction counterpart of the 2x nearest-neighbour zoom-in engine. It sits between the primary frame RAM (read port) and the output frame RAM (write port), and is started by the same control logic that starts the zoom-in.

## Interface
- SRC_W, 320, source and destination line pitch in pixels
- OUT_W, 160, output width in pixels
- OUT_H, 120, output height in lines
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  level sampled in IDLE; begins one frame pass
- offset_x  in  8  destination window X origin; latched at start
- offset_y  in  8  destination window Y origin; latched at start
- pixel_data  in  8  source RAM read data; valid 2 edges after the edge that updated rd_address
- rd_address  out  17  source RAM read address, registered
- wr_address  out  17  destination RAM write address, registered
- wr_data  out  8  destination write data, registered
- wren  out  1  destination write enable; one-cycle pulse per output pixel
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse at end of pass

## Operation
- Reset values: rd_address=0, wr_address=0, wr_data=0, wren=0, busy=0, done=0, state=IDLE, x=0, y=0, sum=0.
- Output coordinates: x in 0..159 (8 bit), y in 0..119 (7 bit). Raster order, x fastest.
- Source address: src(sx,sy) = sy*320 + sx, where sx ∈ {2x, 2x+1} and sy ∈ {2y, 2y+1}. Maximum is 76799.
- Offsets are latched at start and clamped: ox = min(offset_x,160), oy = min(offset_y,120).
- Destination address: (y+oy)*320 + (x+ox). Maximum is 76799. No wrap.
- sum is a 10-bit accumulator. Result = (sum + 2) >> 2, i.e. round half up. Maximum (1020+2)>>2 = 255, so it never overflows 8 bits.
- FSM actions, one edge per state:
  - IDLE: wren<=0, done<=0. If start: latch/clamp offsets, x<=0, y<=0, busy<=1, go to RD0.
  - RD0: rd_address<=src(2x,2y); wren<=0; go to RD1.
  - RD1: rd_address<=src(2x+1,2y); go to RD2.
  - RD2: rd_address<=src(2x,2y+1); sum<=pixel_data; go to RD3.
  - RD3: rd_address<=src(2x+1,2y+1); sum<=sum+pixel_data; go to ACC0.
  - ACC0: sum<=sum+pixel_data; go to ACC1.
  - ACC1: wr_data<=(sum+pixel_data+2)>>2; wr_address<=dest(x,y); wren<=1.
    - Advance x. If x==159, set x<=0 and advance y.
    - If x==159 and y==119, go to DONE_ST; otherwise go to RD0.
  - DONE_ST: wren<=0, done<=1, busy<=0; go to IDLE.
  - Undefined state: go to IDLE.
- start is ignored outside IDLE. Holding start high re-triggers a new pass on the first IDLE edge after done.
- Only the 160x120 window is written. Destination pixels outside the window are untouched.

## Timing
- Let E0 be the edge at which start is sampled in IDLE.
- First rd_address is updated at E1. Read addresses are issued on 4 consecutive edges per output pixel.
- Output pixel n (0..19199) asserts wren at edge E6+6n, with its wr_address/wr_data valid on that same edge. wren falls at the next edge.
- Throughput is 6 cycles per output pixel: 115200 cycles per frame.
- The last wren is at E115200. done is high for the single cycle after E115201; busy falls at E115201.
- Read latency is fixed at 2 edges. A RAM with any other latency is out of spec.
- rst mid-pass: at the next edge all outputs return to reset values, with no further wren. A new start is required.
- rst and start asserted together: rst wins.

## Test plan
- Uniform source of 0x80, offsets (80,60) -> 19200 wren pulses, all wr_data=0x80. First wr_address=60*320+80=19280, last=179*320+239=57519. done at E115201.
- Block src(0,0)=10, (1,0)=20, (0,1)=30, (1,1)=41, all other pixels 0 -> first write wr_data=(101+2)>>2=25. Block 1,1,1,2 -> 1. Block 255 x4 -> 255. Block 1,1,2,2 -> 2.
- Offsets (0,0) -> first wr_address=0, last=38239. Offsets (200,200) -> clamped to (160,120), first=38560, last=76799. Changing offset inputs mid-pass has no effect.
- rd_address sequence for output (1,0) -> 2, 3, 322, 323 on consecutive edges from E7. Output (159,119) -> last read 76799.
- Pulse start while busy at random points -> no restart, pass completes with exactly 19200 writes. Start held high -> second pass begins at E115202.
- rst asserted at pixel 5000 -> wren=0, busy=0, done=0 on the next edge, no done pulse. A subsequent start performs a full clean pass.
